// File: rtl/twiddle_gen_pkg.sv
// Shared FFT parameters and elaboration-time helpers for the twiddle generator.
// The FFT_* defaults are the values the butterfly and controller also import.
package twiddle_gen_pkg;

  localparam int FFT_N_POINTS = 32;
  localparam int FFT_DW       = 8;
  localparam int FFT_FRAC     = 6;

  localparam real TW_PI = 3.14159265358979323846;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  // Quarter-wave cosine entry, rounded half away from zero; elaboration use only.
  function automatic int qcos(input int m, input int n, input int frac);
    real x;
    x = $cos(2.0 * TW_PI * real'(m) / real'(n)) * real'(1 << frac);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Dual-read registered quarter-wave cosine ROM, N/4+1 entries filled at elaboration.
module twiddle_qrom
  import twiddle_gen_pkg::*;
#(
  parameter int N_POINTS = FFT_N_POINTS,
  parameter int DW       = FFT_DW,
  parameter int FRAC     = FFT_FRAC,
  localparam int QAW     = $clog2(N_POINTS) - 1
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [QAW-1:0]       addr_a,
  input  logic [QAW-1:0]       addr_b,
  output logic signed [DW-1:0] data_a,
  output logic signed [DW-1:0] data_b
);

  localparam int DEPTH = N_POINTS / 4 + 1;

  logic signed [DW-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam int CV = qcos(g, N_POINTS, FRAC);
    assign rom[g] = DW'(CV);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/twiddle_gen.sv
// FFT twiddle factor generator: single lookups or strided auto-sequences,
// three-register pipeline (request, ROM, fold) with a global hold.
module twiddle_gen
  import twiddle_gen_pkg::*;
#(
  parameter int N_POINTS = FFT_N_POINTS,
  parameter int DW       = FFT_DW,
  parameter int FRAC     = FFT_FRAC,
  localparam int AW      = $clog2(N_POINTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 in_valid,
  input  logic [AW-1:0]        in_addr,
  input  logic                 inv,
  input  logic                 seq_start,
  input  logic [AW-1:0]        seq_stride,
  input  logic [AW:0]          seq_count,
  output logic                 busy,
  output logic                 out_valid,
  output logic                 out_last,
  output logic signed [DW-1:0] tw_real,
  output logic signed [DW-1:0] tw_imag
);

  localparam int QAW = AW - 1;
  localparam logic [QAW-1:0] QTR = QAW'(N_POINTS / 4);

  if (FRAC > DW - 2) begin : g_bad_frac
    $error("twiddle_gen: FRAC must not exceed DW-2");
  end
  if (N_POINTS < 8 || N_POINTS > 1024 || (N_POINTS & (N_POINTS - 1)) != 0) begin : g_bad_n
    $error("twiddle_gen: N_POINTS must be a power of two in 8..1024");
  end

  seq_state_t           state;
  logic [AW-1:0]        seq_k;
  logic [AW-1:0]        seq_step;
  logic [AW:0]          seq_left;
  logic                 seq_inv;

  logic                 req_valid;
  logic [AW-1:0]        req_k;
  logic                 req_inv;
  logic                 req_last;

  logic                 s1_valid;
  logic [1:0]           s1_q;
  logic                 s1_inv;
  logic                 s1_last;

  logic [QAW-1:0]       rom_addr_a;
  logic [QAW-1:0]       rom_addr_b;
  logic signed [DW-1:0] c_r;
  logic signed [DW-1:0] c_nr;
  logic signed [DW-1:0] re_nxt;
  logic signed [DW-1:0] im_raw;
  logic signed [DW-1:0] im_nxt;

  logic                 accept_single;
  logic                 seq_go;

  assign accept_single = in_valid && !busy && !hold && !seq_start;
  assign seq_go        = seq_start && !busy && !hold && (seq_count != '0);

  // Sequencer and request register share one block so a sequence step and a
  // single lookup can never both load the request stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEQ_IDLE;
      busy      <= 1'b0;
      seq_k     <= '0;
      seq_step  <= '0;
      seq_left  <= '0;
      seq_inv   <= 1'b0;
      req_valid <= 1'b0;
      req_k     <= '0;
      req_inv   <= 1'b0;
      req_last  <= 1'b0;
    end else if (!hold) begin
      req_valid <= 1'b0;
      req_last  <= 1'b0;
      case (state)
        SEQ_IDLE: begin
          if (seq_go) begin
            state    <= SEQ_RUN;
            busy     <= 1'b1;
            seq_k    <= '0;
            seq_step <= seq_stride;
            seq_left <= seq_count;
            seq_inv  <= inv;
          end else if (accept_single) begin
            req_valid <= 1'b1;
            req_k     <= in_addr;
            req_inv   <= inv;
          end
        end
        SEQ_RUN: begin
          req_valid <= 1'b1;
          req_k     <= seq_k;
          req_inv   <= seq_inv;
          req_last  <= (seq_left == {{AW{1'b0}}, 1'b1});
          seq_k     <= seq_k + seq_step;
          seq_left  <= seq_left - 1'b1;
          if (seq_left == {{AW{1'b0}}, 1'b1}) begin
            state <= SEQ_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= SEQ_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr_a = {1'b0, req_k[AW-3:0]};
  assign rom_addr_b = QTR - rom_addr_a;

  twiddle_qrom #(
    .N_POINTS (N_POINTS),
    .DW       (DW),
    .FRAC     (FRAC)
  ) u_qrom (
    .clk    (clk),
    .en     (!hold),
    .addr_a (rom_addr_a),
    .addr_b (rom_addr_b),
    .data_a (c_r),
    .data_b (c_nr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_inv   <= 1'b0;
      s1_last  <= 1'b0;
    end else if (!hold) begin
      s1_valid <= req_valid;
      s1_q     <= req_k[AW-1:AW-2];
      s1_inv   <= req_inv;
      s1_last  <= req_last;
    end
  end

  // Quadrant fold: c_r = C[r], c_nr = C[N/4-r].
  always_comb begin
    re_nxt = c_r;
    im_raw = -c_nr;
    case (s1_q)
      2'd0: begin re_nxt = c_r;   im_raw = -c_nr; end
      2'd1: begin re_nxt = -c_nr; im_raw = -c_r;  end
      2'd2: begin re_nxt = -c_r;  im_raw = c_nr;  end
      default: begin re_nxt = c_nr; im_raw = c_r; end
    endcase
    im_nxt = s1_inv ? -im_raw : im_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      tw_real   <= '0;
      tw_imag   <= '0;
    end else if (!hold) begin
      out_valid <= s1_valid;
      out_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        tw_real <= re_nxt;
        tw_imag <= im_nxt;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen at N=32, DW=8, FRAC=6 with hand-computed twiddles.
module tb_twiddle_gen;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic              in_valid;
  logic [4:0]        in_addr;
  logic              inv;
  logic              seq_start;
  logic [4:0]        seq_stride;
  logic [5:0]        seq_count;
  logic              busy;
  logic              out_valid;
  logic              out_last;
  logic signed [7:0] tw_real;
  logic signed [7:0] tw_imag;

  int total = 0;
  int bad   = 0;

  twiddle_gen #(.N_POINTS(32), .DW(8), .FRAC(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .inv        (inv),
    .seq_start  (seq_start),
    .seq_stride (seq_stride),
    .seq_count  (seq_count),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .tw_real    (tw_real),
    .tw_imag    (tw_imag)
  );

  always #5 clk = ~clk;

  // C[] = 64,63,59,53,45,36,24,12,0 folded by hand per index.
  function automatic logic [7:0] exp_re(input int k);
    case (k)
      0:  return 8'h40;
      1:  return 8'h3F;
      2:  return 8'h3B;
      4:  return 8'h2D;
      8:  return 8'h00;
      12: return 8'hD3;
      13: return 8'hCB;
      16: return 8'hC0;
      20: return 8'hD3;
      24: return 8'h00;
      28: return 8'h2D;
      30: return 8'h3B;
      default: return 8'hxx;
    endcase
  endfunction

  function automatic logic [7:0] exp_im(input int k);
    case (k)
      0:  return 8'h00;
      1:  return 8'hF4;
      2:  return 8'hE8;
      4:  return 8'hD3;
      8:  return 8'hC0;
      12: return 8'hD3;
      13: return 8'hDC;
      16: return 8'h00;
      20: return 8'h2D;
      24: return 8'h40;
      28: return 8'h2D;
      30: return 8'h18;
      default: return 8'hxx;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1; hold = 0; in_valid = 0; in_addr = '0; inv = 0;
    seq_start = 0; seq_stride = '0; seq_count = '0;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset out_last: got %b want 0", out_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (tw_real !== 8'h00 || tw_imag !== 8'h00) begin
      bad++; $display("FAIL reset tw: got re=%h im=%h want 00 00", tw_real, tw_imag);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int ks [7] = '{0, 1, 2, 4, 8, 13, 30};
    foreach (ks[i]) begin
      @(negedge clk); in_valid = 1; in_addr = 5'(ks[i]); inv = 0;
      @(negedge clk); in_valid = 0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single k=%0d early1: out_valid=%b want 0", ks[i], out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single k=%0d early2: out_valid=%b want 0", ks[i], out_valid); end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || tw_real !== exp_re(ks[i]) || tw_imag !== exp_im(ks[i]) || out_last !== 1'b0) begin
        bad++;
        $display("FAIL single k=%0d: got v=%b re=%h im=%h last=%b want v=1 re=%h im=%h last=0",
                 ks[i], out_valid, tw_real, tw_imag, out_last, exp_re(ks[i]), exp_im(ks[i]));
      end
    end
  endtask

  task automatic test_inv();
    logic       ivs [2] = '{1'b0, 1'b1};
    logic [7:0] eis [2] = '{8'h40, 8'hC0};
    foreach (ivs[i]) begin
      @(negedge clk); in_valid = 1; in_addr = 5'd24; inv = ivs[i];
      @(negedge clk); in_valid = 0; inv = 0;
      repeat (2) @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || tw_real !== 8'h00 || tw_imag !== eis[i]) begin
        bad++;
        $display("FAIL inv k=24 inv=%b: got v=%b re=%h im=%h want v=1 re=00 im=%h",
                 ivs[i], out_valid, tw_real, tw_imag, eis[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ks [4] = '{4, 12, 20, 28};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        total++;
        if (out_valid !== 1'b1 || tw_real !== exp_re(ks[i-3]) || tw_imag !== exp_im(ks[i-3])) begin
          bad++;
          $display("FAIL b2b item %0d k=%0d: got v=%b re=%h im=%h want v=1 re=%h im=%h",
                   i - 3, ks[i-3], out_valid, tw_real, tw_imag, exp_re(ks[i-3]), exp_im(ks[i-3]));
        end
      end
      if (i < 4) begin in_valid = 1; in_addr = 5'(ks[i]); end
      else in_valid = 0;
    end
  endtask

  task automatic test_drop();
    int seen;
    @(negedge clk); hold = 1; in_valid = 1; in_addr = 5'd4;
    @(negedge clk);
    @(negedge clk); hold = 0; in_valid = 0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL drop under hold: got %0d outputs want 0", seen); end
    // seq_start with count 0 both starts nothing and blocks the single request
    @(negedge clk); seq_start = 1; seq_count = '0; seq_stride = 5'd4; in_valid = 1; in_addr = 5'd8;
    @(negedge clk); seq_start = 0; in_valid = 0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL count0 busy: got %b want 0", busy); end
    seen = 0;
    repeat (5) begin @(negedge clk); if (out_valid === 1'b1 || busy === 1'b1) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL count0 activity: got %0d active cycles want 0", seen); end
  endtask

  task automatic run_seq(input int stride, input int count, input int hold_at, input string tag);
    int n;
    int k;
    int cyc;
    int extra;
    @(negedge clk); seq_start = 1; seq_stride = 5'(stride); seq_count = 6'(count); inv = 0;
    @(negedge clk); seq_start = 0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy after start: got %b want 1", tag, busy); end
    n = 0; cyc = 0;
    while (n < count && cyc < 60) begin
      @(negedge clk); cyc++;
      if (out_valid === 1'b1) begin
        k = (n * stride) % 32;
        total++;
        if (tw_real !== exp_re(k) || tw_imag !== exp_im(k)) begin
          bad++;
          $display("FAIL %s step %0d k=%0d: got re=%h im=%h want re=%h im=%h",
                   tag, n, k, tw_real, tw_imag, exp_re(k), exp_im(k));
        end
        total++;
        if (out_last !== (n == count - 1)) begin
          bad++; $display("FAIL %s step %0d out_last: got %b want %b", tag, n, out_last, (n == count - 1));
        end
        n++;
        if (n == count) begin
          total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy at last: got %b want 0", tag, busy); end
        end
        if (n == hold_at) begin
          hold = 1;
          repeat (3) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || tw_real !== exp_re(k) || tw_imag !== exp_im(k) || busy !== 1'b1) begin
              bad++;
              $display("FAIL %s hold frozen: got v=%b re=%h im=%h busy=%b want v=1 re=%h im=%h busy=1",
                       tag, out_valid, tw_real, tw_imag, busy, exp_re(k), exp_im(k));
            end
          end
          hold = 0;
        end
      end else if (n > 0) begin
        total++; bad++;
        $display("FAIL %s gap at step %0d: got out_valid=%b want 1", tag, n, out_valid);
      end
    end
    total++; if (n != count) begin bad++; $display("FAIL %s timeout: got %0d outputs want %0d", tag, n, count); end
    extra = 0;
    repeat (3) begin @(negedge clk); if (out_valid === 1'b1) extra++; end
    total++; if (extra != 0) begin bad++; $display("FAIL %s extra outputs: got %0d want 0", tag, extra); end
  endtask

  task automatic test_seq();
    run_seq(4, 8, -1, "seq_s4_c8");
  endtask

  task automatic test_wrap();
    run_seq(12, 4, -1, "seq_s12_c4");
  endtask

  task automatic test_hold();
    run_seq(4, 8, 3, "seq_hold");
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen;
    @(negedge clk); seq_start = 1; seq_stride = 5'd4; seq_count = 6'd8;
    @(negedge clk); seq_start = 0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_mid no output before reset: got %b want 1", out_valid); end
    @(negedge clk); rst = 1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || tw_real !== 8'h00 || tw_imag !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid cleared: got v=%b last=%b busy=%b re=%h im=%h want all 0",
               out_valid, out_last, busy, tw_real, tw_imag);
    end
    rst = 0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (out_valid === 1'b1 || busy === 1'b1) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid leftover: got %0d active cycles want 0", seen); end
    run_seq(12, 4, -1, "seq_after_rst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_inv();
    test_back_to_back();
    test_drop();
    test_seq();
    test_wrap();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
